// File: rtl/entropy_poll_ctrl.sv
// Entropy source controller answering pollentropy loads at POLLENTROPY_PADDR.
// Optional repetition count health test enabled by defining POLLENTROPY_RCT_EN.
`timescale 1ns/1ps
module entropy_poll_ctrl #(
    parameter logic [31:0] POLLENTROPY_PADDR = 32'h7000_0000,
    parameter int          FIFO_DEPTH        = 4,
    parameter int          BIST_SAMPLES      = 64,
    parameter int          RCT_CUTOFF        = 32
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        noise_valid,
    input  logic        noise_bit,
    input  logic        mem_req,
    output logic        mem_gnt,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_recv,
    input  logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata,
    output logic        dead
);

    // state   | meaning
    // ST_BIST | start-up self test, samples counted, nothing buffered
    // ST_RUN  | words pushed to FIFO; OPST is ES16 or WAIT by FIFO occupancy
    // ST_DEAD | health test failed, sticky until reset

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int SCW = $clog2(BIST_SAMPLES + 1);

    localparam logic [1:0] OPST_BIST = 2'b00;
    localparam logic [1:0] OPST_WAIT = 2'b01;
    localparam logic [1:0] OPST_ES16 = 2'b10;
    localparam logic [1:0] OPST_DEAD = 2'b11;

    typedef enum logic [1:0] {
        ST_BIST = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [15:0]      r_sr;
    logic [3:0]       r_bit_cnt;
    logic [SCW-1:0]   r_sample_cnt;

    logic [15:0]      r_fifo [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic             r_recv;
    logic             r_error;
    logic [31:0]      r_rdata;

    logic             w_sample;
    logic [15:0]      w_sr_nxt;
    logic             w_word_done;
    logic             w_rct_fail;
    logic [AW:0]      w_count;
    logic             w_empty;
    logic             w_full;
    logic [1:0]       w_opst;
    logic [15:0]      w_seed;
    logic             w_accept;
    logic             w_read_ok;
    logic             w_pop;
    logic             w_push;
    logic             w_unused;

    assign w_sample    = noise_valid && (r_state != ST_DEAD);
    assign w_sr_nxt    = {r_sr[14:0], noise_bit};
    assign w_word_done = w_sample && (r_bit_cnt == 4'd15);

`ifdef POLLENTROPY_RCT_EN
    localparam int RCW = $clog2(RCT_CUTOFF + 1);

    logic [RCW-1:0] r_run_cnt;
    logic [RCW-1:0] w_run_nxt;

    // r_sr[0] is the previous sample; a zero run count means there is none yet
    always_comb begin
        w_run_nxt = RCW'(1);
        if ((r_run_cnt != '0) && (noise_bit == r_sr[0]))
            w_run_nxt = r_run_cnt + 1'b1;
    end

    assign w_rct_fail = w_sample && (w_run_nxt == RCW'(RCT_CUTOFF));

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset)
            r_run_cnt <= '0;
        else if (w_sample)
            r_run_cnt <= w_run_nxt;
    end
`else
    assign w_rct_fail = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BIST: begin
                if (w_rct_fail)
                    w_state_nxt = ST_DEAD;
                else if (w_sample && (r_sample_cnt == SCW'(BIST_SAMPLES - 1)))
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_rct_fail)
                    w_state_nxt = ST_DEAD;
            end
            ST_DEAD: w_state_nxt = ST_DEAD;
            default: w_state_nxt = ST_DEAD;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset)
            r_state <= ST_BIST;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_sr         <= '0;
            r_bit_cnt    <= '0;
            r_sample_cnt <= '0;
        end else if (w_sample) begin
            r_sr      <= w_sr_nxt;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_state == ST_BIST)
                r_sample_cnt <= r_sample_cnt + 1'b1;
        end
    end

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = w_count[AW];

    always_comb begin
        w_opst = OPST_DEAD;
        case (r_state)
            ST_BIST: w_opst = OPST_BIST;
            ST_RUN:  w_opst = w_empty ? OPST_WAIT : OPST_ES16;
            default: w_opst = OPST_DEAD;
        endcase
    end

    assign w_seed    = (w_opst == OPST_ES16) ? r_fifo[r_rd_ptr[AW-1:0]] : 16'h0;
    assign w_accept  = mem_req && !r_recv;
    assign w_read_ok = !mem_wen && (mem_addr == POLLENTROPY_PADDR);
    assign w_pop     = w_accept && w_read_ok && (w_opst == OPST_ES16);
    // a full FIFO still takes the new word when the head leaves in the same cycle
    assign w_push    = w_word_done && (r_state == ST_RUN) && (!w_full || w_pop) && !w_rct_fail;

    always_ff @(posedge g_clk) begin
        if (w_push)
            r_fifo[r_wr_ptr[AW-1:0]] <= w_sr_nxt;
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_rct_fail) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_recv  <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_recv  <= 1'b1;
            r_error <= !w_read_ok;
            r_rdata <= w_read_ok ? {w_opst, 14'b0, w_seed} : 32'h0;
        end else if (r_recv && mem_ack) begin
            r_recv <= 1'b0;
        end
    end

    assign mem_gnt   = !r_recv;
    assign mem_recv  = r_recv;
    assign mem_error = r_error;
    assign mem_rdata = r_rdata;
    assign dead      = (r_state == ST_DEAD);

    assign w_unused = ^{mem_strb, mem_wdata, r_sr[15]};

endmodule

// File: tb/tb_entropy_poll_ctrl.sv
// Self-checking bench for entropy_poll_ctrl: queue-based reference model plus directed reads.
`timescale 1ns/1ps
module tb_entropy_poll_ctrl;

    localparam logic [31:0] PADDR = 32'h7000_0000;
`ifdef POLLENTROPY_RCT_EN
    localparam bit RCT_ON = 1'b1;
`else
    localparam bit RCT_ON = 1'b0;
`endif

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        noise_valid = 1'b0;
    logic        noise_bit = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_gnt;
    logic        mem_wen = 1'b0;
    logic [3:0]  mem_strb = 4'hF;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_addr = 32'h0;
    logic        mem_recv;
    logic        mem_ack = 1'b0;
    logic        mem_error;
    logic [31:0] mem_rdata;
    logic        dead;

    int n_checks = 0;
    int n_fail   = 0;

    entropy_poll_ctrl dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .noise_valid(noise_valid), .noise_bit(noise_bit),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
        .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
        .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error),
        .mem_rdata(mem_rdata), .dead(dead)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=BIST 1=RUN 3=DEAD, FIFO as a bounded queue
    int          m_mode;
    logic [15:0] m_q[$];
    int          m_nbits, m_samples, m_run;
    logic [15:0] m_bits;
    logic        m_prev;
    logic        m_recv, m_err;
    logic [31:0] m_rdata;
    logic [1:0]  m_opst;
    logic        m_acc, m_rdok, m_pop;

    always @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            m_mode = 0; m_q.delete(); m_nbits = 0; m_samples = 0; m_run = 0;
            m_bits = 16'h0; m_prev = 1'b0; m_recv = 1'b0; m_err = 1'b0; m_rdata = 32'h0;
        end else begin
            m_opst = (m_mode == 0) ? 2'd0 : (m_mode == 3) ? 2'd3 : (m_q.size() > 0) ? 2'd2 : 2'd1;
            m_acc  = mem_req && !m_recv;
            m_rdok = !mem_wen && (mem_addr == PADDR);
            m_pop  = 1'b0;
            if (m_acc) begin
                m_recv  = 1'b1;
                m_err   = !m_rdok;
                m_rdata = m_rdok ? {m_opst, 14'b0, (m_opst == 2'd2) ? m_q[0] : 16'h0} : 32'h0;
                m_pop   = m_rdok && (m_opst == 2'd2);
            end else if (m_recv && mem_ack) begin
                m_recv = 1'b0;
            end
            if (m_pop) void'(m_q.pop_front());
            if (noise_valid && m_mode != 3) begin
                m_run  = (m_run > 0 && noise_bit == m_prev) ? m_run + 1 : 1;
                m_prev = noise_bit;
                m_bits = {m_bits[14:0], noise_bit};
                m_nbits++;
                if (m_nbits == 16) begin
                    m_nbits = 0;
                    if (m_mode == 1 && m_q.size() < 4) m_q.push_back(m_bits);
                end
                m_samples++;
                if (m_mode == 0 && m_samples == 64) m_mode = 1;
                if (RCT_ON && m_run >= 32) begin
                    m_mode = 3;
                    m_q.delete();
                end
            end
        end
    end

    always @(negedge g_clk) begin
        if (!g_reset) begin
            chk("model_gnt", {31'b0, mem_gnt}, {31'b0, !m_recv});
            chk("model_recv", {31'b0, mem_recv}, {31'b0, m_recv});
            chk("model_dead", {31'b0, dead}, {31'b0, m_mode == 3});
            if (m_recv) begin
                chk("model_rdata", mem_rdata, m_rdata);
                chk("model_error", {31'b0, mem_error}, {31'b0, m_err});
            end
        end
    end

    task automatic feed_bit(input logic b);
        @(negedge g_clk);
        noise_valid = 1'b1;
        noise_bit   = b;
    endtask

    task automatic feed_idle();
        @(negedge g_clk);
        noise_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) feed_bit(w[i]);
        feed_idle();
    endtask

    task automatic feed_alt(input int n);
        for (int i = 0; i < n; i++) feed_bit(i % 2 == 1);
        feed_idle();
    endtask

    task automatic access(input string name, input logic wen, input logic [31:0] addr,
                          input logic [31:0] exp_d, input logic exp_e, input int ack_delay);
        int n;
        @(negedge g_clk);
        mem_req = 1'b1; mem_wen = wen; mem_addr = addr;
        n = 0;
        while (!mem_gnt && n < 20) begin
            @(negedge g_clk);
            n++;
        end
        chk({name, "_gnt_timeout"}, {31'b0, mem_gnt}, 32'd1);
        @(negedge g_clk);
        mem_req = 1'b0; mem_wen = 1'b0;
        chk({name, "_recv"}, {31'b0, mem_recv}, 32'd1);
        for (int i = 0; i < ack_delay; i++) begin
            chk({name, "_hold_rdata"}, mem_rdata, exp_d);
            chk({name, "_hold_gnt"}, {31'b0, mem_gnt}, 32'd0);
            @(negedge g_clk);
        end
        chk({name, "_rdata"}, mem_rdata, exp_d);
        chk({name, "_error"}, {31'b0, mem_error}, {31'b0, exp_e});
        mem_ack = 1'b1;
        @(negedge g_clk);
        mem_ack = 1'b0;
        chk({name, "_recv_fall"}, {31'b0, mem_recv}, 32'd0);
    endtask

    task automatic rd(input string name, input logic [31:0] exp_d);
        access(name, 1'b0, PADDR, exp_d, 1'b0, 0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge g_clk);
        chk("reset_recv", {31'b0, mem_recv}, 32'd0);
        chk("reset_gnt", {31'b0, mem_gnt}, 32'd1);
        chk("reset_rdata", mem_rdata, 32'h0);
        chk("reset_dead", {31'b0, dead}, 32'd0);
        g_reset = 1'b0;

        rd("t1_bist", 32'h0000_0000);

        feed_alt(64);
        rd("t2_wait", 32'h4000_0000);
        feed_word(16'hA5A5);
        rd("t2_word", 32'h8000_A5A5);
        rd("t2_empty", 32'h4000_0000);

        feed_word(16'h1234);
        access("t5_write", 1'b1, PADDR, 32'h0, 1'b1, 0);
        access("t5_badaddr", 1'b0, 32'h7000_0004, 32'h0, 1'b1, 0);
        rd("t5_kept", 32'h8000_1234);

        feed_word(16'h1111); feed_word(16'h2222); feed_word(16'h3333);
        feed_word(16'h4444); feed_word(16'h5555);
        rd("t3_w1", 32'h8000_1111);
        rd("t3_w2", 32'h8000_2222);
        rd("t3_w3", 32'h8000_3333);
        rd("t3_w4", 32'h8000_4444);
        rd("t3_drop", 32'h4000_0000);

        feed_word(16'h1111); feed_word(16'h2222); feed_word(16'h3333); feed_word(16'h4444);
        for (int i = 15; i >= 1; i--) feed_bit(i % 2 == 0);
        @(negedge g_clk);
        noise_valid = 1'b1; noise_bit = 1'b1;
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = PADDR;
        @(negedge g_clk);
        noise_valid = 1'b0; mem_req = 1'b0;
        chk("full_pp_rdata", mem_rdata, 32'h8000_1111);
        mem_ack = 1'b1;
        @(negedge g_clk);
        mem_ack = 1'b0;
        rd("full_pp_w2", 32'h8000_2222);
        rd("full_pp_w3", 32'h8000_3333);
        rd("full_pp_w4", 32'h8000_4444);
        rd("full_pp_w5", 32'h8000_5555);
        rd("full_pp_empty", 32'h4000_0000);

        feed_word(16'hBEEF);
        @(negedge g_clk);
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = PADDR;
        @(negedge g_clk);
        for (int i = 0; i < 3; i++) begin
            chk("t6_hold_recv", {31'b0, mem_recv}, 32'd1);
            chk("t6_hold_rdata", mem_rdata, 32'h8000_BEEF);
            chk("t6_hold_error", {31'b0, mem_error}, 32'd0);
            chk("t6_hold_gnt", {31'b0, mem_gnt}, 32'd0);
            @(negedge g_clk);
        end
        mem_ack = 1'b1;
        @(negedge g_clk);
        mem_ack = 1'b0;
        chk("t6_recv_fall", {31'b0, mem_recv}, 32'd0);
        chk("t6_gnt_back", {31'b0, mem_gnt}, 32'd1);
        @(negedge g_clk);
        mem_req = 1'b0;
        chk("t6_second_recv", {31'b0, mem_recv}, 32'd1);
        chk("t6_second_rdata", mem_rdata, 32'h4000_0000);
        mem_ack = 1'b1;
        @(negedge g_clk);
        mem_ack = 1'b0;

        feed_word(16'h1356);
        for (int i = 0; i < 31; i++) feed_bit(1'b1);
        feed_idle();
        chk("t4_dead_31", {31'b0, dead}, 32'd0);
        feed_bit(1'b1);
        feed_idle();
        if (RCT_ON) begin
            chk("t4_dead_32", {31'b0, dead}, 32'd1);
            rd("t4_dead_read", 32'hC000_0000);
            feed_alt(100);
            chk("t4_dead_sticky", {31'b0, dead}, 32'd1);
            rd("t4_dead_read2", 32'hC000_0000);
        end else begin
            chk("t4_no_rct", {31'b0, dead}, 32'd0);
            rd("t4_no_rct_read", 32'h8000_1356);
        end

        @(negedge g_clk);
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = PADDR;
        @(negedge g_clk);
        mem_req = 1'b0;
        g_reset = 1'b1;
        @(negedge g_clk);
        chk("rst_mid_recv", {31'b0, mem_recv}, 32'd0);
        chk("rst_mid_dead", {31'b0, dead}, 32'd0);
        g_reset = 1'b0;
        rd("rst_mid_read", 32'h0000_0000);

        repeat (2) @(negedge g_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
